// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Sequences writes from NREQ requesters into a clockless bank of 2^AW
//   level-sensitive D latches, each DW bits wide. Each write runs a fixed
//   SETUP / OPEN / HOLD pulse so that lat_d is stable for one full cycle
//   on both sides of the single-cycle lat_en window.
//
//   Build option: define LATCH_ARB_RR_EN for round-robin arbitration
//   (search starts after the last winner). Leave it undefined for fixed
//   priority, where the lowest index wins.
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   req     per-requester write request, held until done
//   addr    packed target entry, requester i at [i*AW +: AW]
//   wdata   packed write data, requester i at [i*DW +: DW]
//   gnt     one-hot grant, SETUP through HOLD
//   done    one-cycle completion pulse in HOLD
//   lat_d   shared latch D bus, holds last written value while idle
//   lat_en  one-hot latch enable, only in OPEN
//   busy    high whenever the sequencer is not idle
module latch_bank_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned AW   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [DW-1:0]        lat_d,
   output logic [(1<<AW)-1:0]   lat_en,
   output logic                 busy
);

   localparam int unsigned NE = 1 << AW;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

   state_t            state, state_nx;
   logic [IW-1:0]     win_idx, win_idx_nx;
   logic [AW-1:0]     cap_addr, cap_addr_nx;
   logic [NREQ-1:0]   gnt_nx, done_nx;
   logic [DW-1:0]     lat_d_nx;
   logic [NE-1:0]     lat_en_nx;
   logic              busy_nx;

   logic [IW-1:0]     pick;
   logic [AW-1:0]     pick_addr;
   logic [DW-1:0]     pick_data;
   int unsigned       rank;
   int unsigned       best;

`ifdef LATCH_ARB_RR_EN
   logic [IW-1:0]     ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= IW'(NREQ - 1);
      end else if (state == IDLE && req != '0) begin
         ptr <= pick;
      end
   end
`endif

   // Each requester gets a rank (its distance from the highest-priority
   // slot); the lowest-ranked active requester wins.
   always_comb begin
      pick      = '0;
      pick_addr = '0;
      pick_data = '0;
      rank      = 0;
      best      = NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
`ifdef LATCH_ARB_RR_EN
         rank = (j + 2 * NREQ - 1 - 32'(ptr)) % NREQ;
`else
         rank = j;
`endif
         if (req[j] && (rank < best)) begin
            best      = rank;
            pick      = IW'(j);
            pick_addr = addr[j*AW +: AW];
            pick_data = wdata[j*DW +: DW];
         end
      end
   end

   // Outputs are computed one state ahead and registered, so none of
   // them has a combinational path from req.
   always_comb begin
      state_nx    = state;
      win_idx_nx  = win_idx;
      cap_addr_nx = cap_addr;
      gnt_nx      = gnt;
      done_nx     = '0;
      lat_en_nx   = '0;
      lat_d_nx    = lat_d;
      case (state)
         IDLE: begin
            if (req != '0) begin
               state_nx    = SETUP;
               win_idx_nx  = pick;
               cap_addr_nx = pick_addr;
               lat_d_nx    = pick_data;
               gnt_nx      = NREQ'(1) << pick;
            end
         end
         SETUP: begin
            state_nx  = OPEN;
            lat_en_nx = NE'(1) << cap_addr;
         end
         OPEN: begin
            state_nx = HOLD;
            done_nx  = NREQ'(1) << win_idx;
         end
         HOLD: begin
            state_nx = IDLE;
            gnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         win_idx  <= '0;
         cap_addr <= '0;
         gnt      <= '0;
         done     <= '0;
         lat_en   <= '0;
         lat_d    <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         win_idx  <= win_idx_nx;
         cap_addr <= cap_addr_nx;
         gnt      <= gnt_nx;
         done     <= done_nx;
         lat_en   <= lat_en_nx;
         lat_d    <= lat_d_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
`timescale 1ns/1ps
module tb_latch_bank_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int AW   = 2;
   localparam int NE   = 1 << AW;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*AW-1:0]  addr = '0;
   logic [NREQ*DW-1:0]  wdata = '0;
   logic [NREQ-1:0]     gnt, done;
   logic [DW-1:0]       lat_d;
   logic [NE-1:0]       lat_en;
   logic                busy;

   int n_chk  = 0;
   int n_fail = 0;

   latch_bank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct { int who; int a; int d; int t; } exp_t;
   exp_t exp_q[$];

   int             cyc    = 0;
   int             m_skip = 0;       // cycles still owned by the current write
   int             m_who  = 0;
   int             m_last = NREQ - 1;
   int             m_w;
   logic [DW-1:0]  m_lastd = '0;
   exp_t           m_e;

   function automatic int pick_winner(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_skip  = 0;
         m_last  = NREQ - 1;
         m_lastd = '0;
         exp_q.delete();
      end else begin
         cyc++;
         if (m_skip != 0) begin
            m_skip--;
         end else if (req != '0) begin
            m_w     = pick_winner(req, m_last);
            m_e.who = m_w;
            m_e.a   = int'(addr[m_w*AW +: AW]);
            m_e.d   = int'(wdata[m_w*DW +: DW]);
            m_e.t   = cyc;
            exp_q.push_back(m_e);
            m_who   = m_w;
            m_lastd = DW'(m_e.d);
            m_skip  = 3;
`ifdef LATCH_ARB_RR_EN
            m_last  = m_w;
`endif
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [NREQ-1:0] prev_gnt = '0;
   logic [NREQ-1:0] done_q   = '0;
   logic [NE-1:0]   en_val   = '0;
   logic [DW-1:0]   en_d     = '0;
   logic [DW-1:0]   d_setup  = '0;
   int              g_cyc    = 0;
   int              en_cyc   = 0;
   exp_t            e;

   always @(negedge clk) begin
      done_q = done;
      if (rst) begin
         prev_gnt = '0;
         en_val   = '0;
      end else begin
         check("busy", busy, 64'(m_skip != 0));
         check("gnt", gnt, (m_skip != 0) ? (64'(1) << m_who) : 64'd0);
         check("lat_d", lat_d, m_lastd);
         if (gnt != '0 && prev_gnt == '0) begin
            g_cyc   = cyc;
            d_setup = lat_d;
         end
         if (lat_en != '0) begin
            if (exp_q.size() == 0) check("stray_lat_en", lat_en, 0);
            en_val = lat_en;
            en_cyc = cyc;
            en_d   = lat_d;
         end
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               check("stray_done", done, 0);
            end else begin
               e = exp_q.pop_front();
               check("done_who", done, 64'(1) << e.who);
               check("grant_cycle", g_cyc, e.t);
               check("setup_data", d_setup, e.d);
               check("en_addr", en_val, 64'(1) << e.a);
               check("en_cycle", en_cyc, e.t + 1);
               check("en_data", en_d, e.d);
               check("hold_data", lat_d, e.d);
               check("hold_en_low", lat_en, 0);
               check("done_cycle", cyc, e.t + 2);
            end
            en_val = '0;
         end
         prev_gnt = gnt;
      end
   end

   // ---------------- stimulus ----------------
   logic [NREQ-1:0] auto_drop = '0;
   bit              rand_on   = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (done_q[i] && auto_drop[i]) begin
            req[i] = 1'b0;
         end else if (rand_on && !req[i] && $urandom_range(0, 3) == 0) begin
            req[i]               = 1'b1;
            addr[i*AW +: AW]     = AW'($urandom);
            wdata[i*DW +: DW]    = DW'($urandom);
         end
      end
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 200; k++) begin
         tick();
         if (req == '0 && m_skip == 0) break;
      end
      check({nm, "_drained"}, 64'(req == '0 && m_skip == 0 && exp_q.size() == 0), 1);
   endtask

   task automatic wait_lat_en(input logic [NE-1:0] v, input int lim);
      for (int k = 0; k < lim; k++) begin
         @(negedge clk);
         if (lat_en == v) break;
      end
      check("wait_lat_en", lat_en, v);
   endtask

   task automatic wait_done(input int idx, input int lim);
      for (int k = 0; k < lim; k++) begin
         @(negedge clk);
         if (done[idx]) break;
      end
      check("wait_done", done[idx], 1);
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #1 rst = 1'b1;
      #2;
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_lat_en", lat_en, 0);
      check("rst_lat_d", lat_d, 0);
      check("rst_busy", busy, 0);
      @(negedge clk); #2 rst = 1'b0;

      // single write: requester 0, entry 2, data A5
      tick();
      auto_drop = 4'b1111;
      req[0] = 1'b1; addr[0*AW +: AW] = 2'd2; wdata[0*DW +: DW] = 8'hA5;
      drain("single");

      // mid-transaction change is ignored
      tick();
      req[0] = 1'b1; addr[0*AW +: AW] = 2'd1; wdata[0*DW +: DW] = 8'h3C;
      tick();
      check("mid_gnt", gnt, 4'b0001);
      wdata[0*DW +: DW] = 8'hFF; req[0] = 1'b0;
      drain("midchange");

      // late request rising in HOLD of another write
      tick();
      req[0] = 1'b1; addr[0*AW +: AW] = 2'd3; wdata[0*DW +: DW] = 8'h11;
      wait_done(0, 10);
      #1;
      req[1] = 1'b1; addr[1*AW +: AW] = 2'd0; wdata[1*DW +: DW] = 8'h5A;
      drain("late");

      // all four contending, each drops after its done
      tick();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = 1'b1;
         addr[i*AW +: AW]  = AW'(NREQ - 1 - i);
         wdata[i*DW +: DW] = DW'(8'h40 + i);
      end
      drain("contend_all");

      // requester 0 held permanently with requester 2 pending
      tick();
      auto_drop[0] = 1'b0;
      req[0] = 1'b1; addr[0*AW +: AW] = 2'd0; wdata[0*DW +: DW] = 8'h01;
      req[2] = 1'b1; addr[2*AW +: AW] = 2'd2; wdata[2*DW +: DW] = 8'h22;
      repeat (24) tick();
      req[0] = 1'b0; auto_drop[0] = 1'b1;
      drain("starve");

      // reset while entry 1 is open
      tick();
      req[1] = 1'b1; addr[1*AW +: AW] = 2'd1; wdata[1*DW +: DW] = 8'h77;
      wait_lat_en(4'b0010, 10);
      #1 rst = 1'b1;
      #1;
      check("midrst_lat_en", lat_en, 0);
      check("midrst_gnt", gnt, 0);
      check("midrst_done", done, 0);
      check("midrst_lat_d", lat_d, 0);
      check("midrst_busy", busy, 0);
      req = '0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (6) tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_gnt", gnt, 0);

      // randomized traffic
      rand_on = 1'b1;
      repeat (400) tick();
      rand_on = 1'b0;
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/latch_bank_arbiter.md
# latch_bank_arbiter

- Sequences writes into a bank of level-sensitive D latches (2^AW entries, DW bits each) on behalf of NREQ requesters.
- Arbitrates among pending requests and captures the winner's address and data.
- Drives the shared latch data bus and a one-hot latch enable, using a setup/open/hold pulse so that D is stable around every enable window.
- Sits between the requesting control logic and the latch array, which is itself clockless.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, latch data width
- AW, 2, latch address width; the bank holds 2^AW latch entries

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request, held high until done
- addr  input  NREQ*AW  packed target entry per requester; requester i uses bits [i*AW +: AW]
- wdata  input  NREQ*DW  packed write data per requester; requester i uses bits [i*DW +: DW]
- gnt  output  NREQ  one-hot, high for the granted requester from SETUP through HOLD
- done  output  NREQ  one-cycle pulse to the granted requester in HOLD
- lat_d  output  DW  shared D bus to all latch entries
- lat_en  output  2^AW  one-hot latch enable; at most one bit is high, and only in OPEN
- busy  output  1  high whenever state is not IDLE

## Operation
- State machine with four states:
  - IDLE: if any req bit is high, pick a winner, register its index, address and data, and go to SETUP. Otherwise stay in IDLE.
  - SETUP: drive lat_d with the captured data; lat_en is all zero. Go to OPEN.
  - OPEN: lat_en[captured addr]=1 and lat_d unchanged. Go to HOLD.
  - HOLD: lat_en all zero, lat_d unchanged, done[winner]=1. Go to IDLE.
- Arbitration happens only in IDLE. A req arriving in any other state waits.
- Captured addr and wdata are frozen at grant. If req drops or inputs change mid-transaction, that is ignored and the write completes with the captured values.
- Requester protocol:
  - Hold req, addr and wdata stable until done is seen.
  - Deassert req in the cycle after done. A req still high when state returns to IDLE is treated as a new request.
- gnt, lat_en, done and busy are registered outputs with no combinational path from req.
- lat_d keeps its last written value while in IDLE.
- Reset forces these outputs to zero immediately: gnt, done, lat_en, lat_d, busy.
- Reset forces state to IDLE and the arbitration pointer to NREQ-1.
- Reset mid-operation:
  - lat_en falls immediately, so the latch keeps whatever value it held at that moment.
  - No done is issued; the interrupted requester must re-request.

## Timing
- Request seen high at edge t (state IDLE) gives:
  - SETUP in cycle t+1, with gnt high;
  - OPEN in cycle t+2, with lat_en high;
  - HOLD in cycle t+3, with done high;
  - IDLE again in cycle t+4.
- Throughput is one write per 4 cycles.
- With continuous contention, the next grant is issued in the cycle after the return to IDLE: the arbiter samples req in the IDLE cycle t+4, and SETUP of the next write is t+5.
- lat_d is stable for at least 1 cycle before and 1 cycle after every lat_en pulse.
- lat_en pulse width is exactly 1 clk period.
- Simultaneous requests are resolved in a single arbitration; requests that lose stay pending.

## Configuration
- LATCH_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at (last winner + 1) mod NREQ.
  - The pointer updates only when a grant is issued.
  - After reset, requester 0 has highest priority.
- LATCH_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - The pointer logic is removed.
  - A continuously requesting requester 0 starves all others.

## Test plan
- Single write: after reset, req=0001, addr0=2, wdata0=0xA5. Required response:
  - gnt=0001 in cycles t+1 to t+3;
  - lat_en=0100 only in t+2;
  - lat_d=0xA5 in t+1 to t+3;
  - done=0001 in t+3;
  - busy low at t+4.
- Contention with RR enabled: req=1111 held, each requester dropping req after its done. Required response:
  - grants in order 0,1,2,3, each 4 cycles apart;
  - no lat_en overlap.
- Contention with RR disabled: req0 held high permanently, req2 high. Required response:
  - requester 0 granted every transaction;
  - gnt[2] never asserts.
- Mid-transaction change: req0 with wdata=0x3C is granted, then wdata changes to 0xFF and req drops in SETUP. Required response:
  - lat_d stays 0x3C through HOLD;
  - done[0] pulses.
- Reset during OPEN: assert rst while lat_en=0010. Required response:
  - lat_en, gnt, done, lat_d and busy go to 0 without waiting for a clk edge;
  - after release with req=0000, the block stays IDLE.
- Late request: req1 rises during HOLD of a req0 write. Required response:
  - req1 is granted with SETUP 2 cycles later;
  - lat_d switches only in its SETUP cycle.
